trdb_packet_parser: RTL and testbench



---
 rtl/trdb_packet_parser.sv | 244 ++++++++++++++++++++++++
 tb/tb_trdb_packet_parser.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_parser.sv
// Trace packet parser: receives a length-prefixed, MSB-first byte stream,
// reassembles the payload into a left-aligned buffer, decodes the
// format/subformat fields and rebuilds absolute addresses for
// differential packets from an internal last-address register.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   byte_i/byte_valid_i/byte_ready_o   incoming byte stream (header then payload)
//   pkt_valid_o/pkt_ready_i    decoded packet handshake
//   format_o, subformat_o      decoded packet type
//   branch_o, priv_o           F_SYNC branch bit and privilege
//   iaddr_o, addr_valid_o      absolute address and its qualifier
//   notify_o, updiscon_o, irreport_o   flag bits
//   branches_o, branch_map_o   branch count and map
//   len_err_o                  one-cycle pulse on a malformed packet
module trdb_packet_parser #(
   parameter int unsigned XLEN              = 32,
   parameter int unsigned PRIV_LEN          = 2,
   parameter int unsigned BRANCH_COUNT_LEN  = 4,
   parameter int unsigned BRANCH_MAP_LEN    = 30,
   parameter int unsigned MAX_PAYLOAD_BYTES = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [7:0]                  byte_i,
   input  logic                        byte_valid_i,
   output logic                        byte_ready_o,
   output logic                        pkt_valid_o,
   input  logic                        pkt_ready_i,
   output logic [1:0]                  format_o,
   output logic [1:0]                  subformat_o,
   output logic                        branch_o,
   output logic [PRIV_LEN:0]           priv_o,
   output logic [XLEN-1:0]             iaddr_o,
   output logic                        addr_valid_o,
   output logic                        notify_o,
   output logic                        updiscon_o,
   output logic                        irreport_o,
   output logic [BRANCH_COUNT_LEN:0]   branches_o,
   output logic [BRANCH_MAP_LEN:0]     branch_map_o,
   output logic                        len_err_o
);

   localparam int unsigned PRIV_W = PRIV_LEN + 1;
   localparam int unsigned BC_W   = BRANCH_COUNT_LEN + 1;
   localparam int unsigned MAP_W  = BRANCH_MAP_LEN + 1;
   localparam int unsigned BUF_W  = MAX_PAYLOAD_BYTES * 8;
   localparam int unsigned CNT_W  = $clog2(MAX_PAYLOAD_BYTES + 1);

   // MSB index of each field inside the left-aligned payload buffer
   localparam int unsigned SS_BRANCH = BUF_W - 5;
   localparam int unsigned SS_PRIV   = BUF_W - 6;
   localparam int unsigned SS_ADDR   = SS_PRIV - PRIV_W;
   localparam int unsigned SC_PRIV   = BUF_W - 5;
   localparam int unsigned AO_ADDR   = BUF_W - 3;
   localparam int unsigned AO_FLAG   = AO_ADDR - XLEN;
   localparam int unsigned DD_BC     = BUF_W - 3;
   localparam int unsigned DD_MAP    = DD_BC - BC_W;
   localparam int unsigned DD_DIFF   = DD_MAP - MAP_W;
   localparam int unsigned DD_FLAG   = DD_DIFF - XLEN;

   // Minimum payload length in bytes for each layout
   localparam int unsigned SS_MIN  = (5 + PRIV_W + XLEN + 7) / 8;
   localparam int unsigned SC_MIN  = (4 + PRIV_W + 7) / 8;
   localparam int unsigned AO_MIN  = (2 + XLEN + 3 + 7) / 8;
   localparam int unsigned DDN_MIN = (2 + BC_W + MAP_W + 7) / 8;
   localparam int unsigned DDA_MIN = (2 + BC_W + MAP_W + XLEN + 3 + 7) / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_DECODE,
      S_OUT
   } state_e;

   state_e             state_q;
   logic [BUF_W-1:0]   buf_q;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [XLEN-1:0]    last_q;

   logic [1:0]         d_fmt;
   logic [1:0]         d_sf;
   logic               d_branch;
   logic [PRIV_W-1:0]  d_priv;
   logic [XLEN-1:0]    d_iaddr;
   logic               d_av;
   logic               d_notify;
   logic               d_updiscon;
   logic               d_irreport;
   logic [BC_W-1:0]    d_bc;
   logic [MAP_W-1:0]   d_map;
   logic [CNT_W-1:0]   d_min;
   logic               d_short;

   // Field extraction from the assembled payload; unused fields stay 0
   always_comb begin
      d_fmt      = buf_q[BUF_W-1 -: 2];
      d_sf       = 2'd0;
      d_branch   = 1'b0;
      d_priv     = '0;
      d_iaddr    = '0;
      d_av       = 1'b0;
      d_notify   = 1'b0;
      d_updiscon = 1'b0;
      d_irreport = 1'b0;
      d_bc       = '0;
      d_map      = '0;
      d_min      = CNT_W'(1);
      case (d_fmt)
         2'd3: begin
            d_sf = buf_q[BUF_W-3 -: 2];
            case (d_sf)
               2'd0: begin
                  d_branch = buf_q[SS_BRANCH];
                  d_priv   = buf_q[SS_PRIV -: PRIV_W];
                  d_iaddr  = buf_q[SS_ADDR -: XLEN];
                  d_av     = 1'b1;
                  d_min    = CNT_W'(SS_MIN);
               end
               2'd2: begin
                  d_priv = buf_q[SC_PRIV -: PRIV_W];
                  d_min  = CNT_W'(SC_MIN);
               end
               default: ;
            endcase
         end
         2'd2: begin
            d_iaddr    = buf_q[AO_ADDR -: XLEN];
            d_notify   = buf_q[AO_FLAG];
            d_updiscon = buf_q[AO_FLAG-1];
            d_irreport = buf_q[AO_FLAG-2];
            d_av       = 1'b1;
            d_min      = CNT_W'(AO_MIN);
         end
         2'd1: begin
            d_bc  = buf_q[DD_BC -: BC_W];
            d_map = buf_q[DD_MAP -: MAP_W];
            // An all-ones branch count means a full map and no address
            if (&d_bc) begin
               d_min = CNT_W'(DDN_MIN);
            end else begin
               d_iaddr    = last_q + buf_q[DD_DIFF -: XLEN];
               d_notify   = buf_q[DD_FLAG];
               d_updiscon = buf_q[DD_FLAG-1];
               d_irreport = buf_q[DD_FLAG-2];
               d_av       = 1'b1;
               d_min      = CNT_W'(DDA_MIN);
            end
         end
         default: ;
      endcase
      d_short = (len_q < d_min);
   end

   // Receive / decode / present state machine with registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         buf_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         last_q       <= '0;
         byte_ready_o <= 1'b0;
         pkt_valid_o  <= 1'b0;
         format_o     <= 2'd0;
         subformat_o  <= 2'd0;
         branch_o     <= 1'b0;
         priv_o       <= '0;
         iaddr_o      <= '0;
         addr_valid_o <= 1'b0;
         notify_o     <= 1'b0;
         updiscon_o   <= 1'b0;
         irreport_o   <= 1'b0;
         branches_o   <= '0;
         branch_map_o <= '0;
         len_err_o    <= 1'b0;
      end else begin
         len_err_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               byte_ready_o <= 1'b1;
               if (byte_valid_i && byte_ready_o) begin
                  if ((byte_i == 8'd0) || (byte_i > 8'(MAX_PAYLOAD_BYTES))) begin
                     len_err_o <= 1'b1;
                  end else begin
                     len_q   <= CNT_W'(byte_i);
                     cnt_q   <= '0;
                     buf_q   <= '0;
                     state_q <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (byte_valid_i && byte_ready_o) begin
                  for (int unsigned k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
                     if (cnt_q == CNT_W'(k)) begin
                        buf_q[BUF_W-1-8*k -: 8] <= byte_i;
                     end
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
                  if ((cnt_q + CNT_W'(1)) == len_q) begin
                     byte_ready_o <= 1'b0;
                     state_q      <= S_DECODE;
                  end
               end
            end
            S_DECODE: begin
               if (d_short) begin
                  len_err_o    <= 1'b1;
                  byte_ready_o <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  format_o     <= d_fmt;
                  subformat_o  <= d_sf;
                  branch_o     <= d_branch;
                  priv_o       <= d_priv;
                  iaddr_o      <= d_iaddr;
                  addr_valid_o <= d_av;
                  notify_o     <= d_notify;
                  updiscon_o   <= d_updiscon;
                  irreport_o   <= d_irreport;
                  branches_o   <= d_bc;
                  branch_map_o <= d_map;
                  pkt_valid_o  <= 1'b1;
                  if (d_av) begin
                     last_q <= d_iaddr;
                  end
                  state_q <= S_OUT;
               end
            end
            S_OUT: begin
               if (pkt_ready_i) begin
                  pkt_valid_o  <= 1'b0;
                  byte_ready_o <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trdb_packet_parser.sv
// Bench for trdb_packet_parser: directed packets, a field-walking model of
// the wire format with its own last-address tracking, and literal checks.
module tb_trdb_packet_parser;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [1:0]  sf;
      logic        branch;
      logic [2:0]  priv;
      logic [31:0] iaddr;
      logic        av;
      logic        notify;
      logic        updiscon;
      logic        irreport;
      logic [4:0]  bc;
      logic [30:0] map;
   } pkt_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic        pkt_valid_o;
   logic        pkt_ready_i;
   logic [1:0]  format_o;
   logic [1:0]  subformat_o;
   logic        branch_o;
   logic [2:0]  priv_o;
   logic [31:0] iaddr_o;
   logic        addr_valid_o;
   logic        notify_o;
   logic        updiscon_o;
   logic        irreport_o;
   logic [4:0]  branches_o;
   logic [30:0] branch_map_o;
   logic        len_err_o;

   trdb_packet_parser dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .pkt_valid_o  (pkt_valid_o),
      .pkt_ready_i  (pkt_ready_i),
      .format_o     (format_o),
      .subformat_o  (subformat_o),
      .branch_o     (branch_o),
      .priv_o       (priv_o),
      .iaddr_o      (iaddr_o),
      .addr_valid_o (addr_valid_o),
      .notify_o     (notify_o),
      .updiscon_o   (updiscon_o),
      .irreport_o   (irreport_o),
      .branches_o   (branches_o),
      .branch_map_o (branch_map_o),
      .len_err_o    (len_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;
   int exp_err = 0;
   int got_err = 0;
   int seen = 0;
   int last_t = 0;
   bit prev_valid = 1'b0;
   pkt_t expq[$];
   pkt_t cap;
   logic [31:0] model_last = 32'h0;
   logic [127:0] mpv;
   int mpos;
   logic [127:0] epv;
   int epos;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Pull the next n bits of the payload, MSB first
   function automatic logic [63:0] grab(input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) begin
         v = {v[62:0], mpv[127-mpos]};
         mpos++;
      end
      return v;
   endfunction

   // Behavioural decoder: walk the fields, then judge length by bits consumed
   task automatic model_pkt(input logic [7:0] n, input logic [127:0] pv);
      pkt_t p;
      logic [31:0] d;
      if (n == 8'd0 || n > 8'd16) begin
         exp_err++;
         return;
      end
      mpv = pv;
      for (int k = int'(n); k < 16; k++) mpv[127-8*k -: 8] = 8'h00;
      mpos = 0;
      p = '0;
      p.fmt = 2'(grab(2));
      case (p.fmt)
         2'd3: begin
            p.sf = 2'(grab(2));
            if (p.sf == 2'd0) begin
               p.branch = 1'(grab(1));
               p.priv   = 3'(grab(3));
               p.iaddr  = 32'(grab(32));
               p.av     = 1'b1;
            end else if (p.sf == 2'd2) begin
               p.priv = 3'(grab(3));
            end
         end
         2'd2: begin
            p.iaddr    = 32'(grab(32));
            p.notify   = 1'(grab(1));
            p.updiscon = 1'(grab(1));
            p.irreport = 1'(grab(1));
            p.av       = 1'b1;
         end
         2'd1: begin
            p.bc  = 5'(grab(5));
            p.map = 31'(grab(31));
            if (p.bc != 5'd31) begin
               d          = 32'(grab(32));
               p.notify   = 1'(grab(1));
               p.updiscon = 1'(grab(1));
               p.irreport = 1'(grab(1));
               p.iaddr    = model_last + d;
               p.av       = 1'b1;
            end
         end
         default: ;
      endcase
      if (mpos > 8 * int'(n)) begin
         exp_err++;
      end else begin
         if (p.av) model_last = p.iaddr;
         expq.push_back(p);
      end
   endtask

   // Present one byte; returns the cycle in which it was accepted
   task automatic send_byte(input logic [7:0] b, output int t);
      bit rdy = 1'b0;
      int guard = 0;
      t = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (!rdy) begin
         @(negedge clk);
         rdy = byte_ready_o;
         t = cyc;
         @(posedge clk);
         #1;
         guard++;
         if (!rdy && guard > 200) begin
            nchk++;
            nerr++;
            $display("FAIL byte_accept: ready stuck low, expected 1");
            break;
         end
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] n, input logic [127:0] pv);
      int t;
      model_pkt(n, pv);
      send_byte(n, t);
      if (n != 8'd0 && n <= 8'd16) begin
         for (int k = 0; k < int'(n); k++) begin
            send_byte(pv[127-8*k -: 8], t);
            last_t = t;
         end
      end
   endtask

   task automatic enc_clear();
      epv = '0;
      epos = 0;
   endtask

   task automatic enc_put(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         epv[127-epos] = v[n-1-i];
         epos++;
      end
   endtask

   task automatic addr_only(input logic [31:0] a, input logic [2:0] fl);
      enc_clear();
      enc_put(64'd2, 2);
      enc_put(64'(a), 32);
      enc_put(64'(fl), 3);
      send_pkt(8'd5, epv);
   endtask

   task automatic diff_delta(input logic [4:0] bc, input logic [30:0] map,
                             input logic [31:0] d, input logic [2:0] fl);
      enc_clear();
      enc_put(64'd1, 2);
      enc_put(64'(bc), 5);
      enc_put(64'(map), 31);
      if (bc != 5'd31) begin
         enc_put(64'(d), 32);
         enc_put(64'(fl), 3);
         send_pkt(8'd10, epv);
      end else begin
         send_pkt(8'd5, epv);
      end
   endtask

   task automatic wait_seen(input int target);
      int guard = 0;
      while (seen < target && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      nchk++;
      if (seen < target) begin
         nerr++;
         $display("FAIL wait_pkt: seen %0d packets, expected %0d", seen, target);
      end
      @(posedge clk);
      #1;
   endtask

   // Per-cycle compare against the model queue
   initial begin
      pkt_t act;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            if (len_err_o) got_err++;
            if (pkt_valid_o) begin
               act.fmt = format_o;          act.sf = subformat_o;
               act.branch = branch_o;       act.priv = priv_o;
               act.iaddr = iaddr_o;         act.av = addr_valid_o;
               act.notify = notify_o;       act.updiscon = updiscon_o;
               act.irreport = irreport_o;   act.bc = branches_o;
               act.map = branch_map_o;
               if (!prev_valid) chk("latency", 64'(cyc), 64'(last_t + 2));
               nchk++;
               if (expq.size() == 0) begin
                  nerr++;
                  $display("FAIL unexpected_pkt: got %h expected none", act);
               end else begin
                  if (act !== expq[0]) begin
                     nerr++;
                     $display("FAIL pkt: got %h expected %h", act, expq[0]);
                  end
                  if (pkt_ready_i) begin
                     cap = act;
                     void'(expq.pop_front());
                     seen++;
                  end
               end
            end
            prev_valid = pkt_valid_o;
         end else begin
            prev_valid = 1'b0;
         end
      end
   end

   initial begin
      int t;
      rst_ni = 1'b0;
      byte_i = 8'h00;
      byte_valid_i = 1'b0;
      pkt_ready_i = 1'b1;
      @(negedge clk);
      chk("rst_pkt_valid", 64'(pkt_valid_o), 64'd0);
      chk("rst_byte_ready", 64'(byte_ready_o), 64'd0);
      chk("rst_iaddr", 64'(iaddr_o), 64'd0);
      chk("rst_len_err", 64'(len_err_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;

      // SF_START from literal bytes
      send_pkt(8'd5, {8'hCB, 8'h80, 8'h00, 8'h01, 8'h00, 88'h0});
      wait_seen(1);
      chk("start_fmt", 64'(cap.fmt), 64'd3);
      chk("start_sf", 64'(cap.sf), 64'd0);
      chk("start_branch", 64'(cap.branch), 64'd1);
      chk("start_priv", 64'(cap.priv), 64'd3);
      chk("start_iaddr", 64'(cap.iaddr), 64'h80000100);
      chk("start_av", 64'(cap.av), 64'd1);

      // Absolute then relative address
      addr_only(32'h0000_1000, 3'b101);
      diff_delta(5'd3, 31'b101, 32'h10, 3'b000);
      wait_seen(3);
      chk("delta_iaddr", 64'(cap.iaddr), 64'h1010);
      chk("delta_bc", 64'(cap.bc), 64'd3);
      chk("delta_map", 64'(cap.map), 64'd5);

      // Full map without address, then a delta still relative to 0x1010
      diff_delta(5'd31, 31'h2AAA_AAAA, 32'h0, 3'b000);
      wait_seen(4);
      chk("noaddr_av", 64'(cap.av), 64'd0);
      chk("noaddr_map", 64'(cap.map), 64'h2AAAAAAA);
      diff_delta(5'd1, 31'd1, 32'h4, 3'b110);
      wait_seen(5);
      chk("after_noaddr_iaddr", 64'(cap.iaddr), 64'h1014);

      // Address wrap
      addr_only(32'hFFFF_FFF8, 3'b000);
      diff_delta(5'd0, 31'd0, 32'h10, 3'b000);
      wait_seen(7);
      chk("wrap_iaddr", 64'(cap.iaddr), 64'h8);

      // Malformed lengths
      send_pkt(8'h00, 128'h0);
      send_pkt(8'h11, 128'h0);
      send_pkt(8'd3, {8'hCB, 8'h80, 8'h00, 8'h01, 8'h00, 88'h0});
      diff_delta(5'd0, 31'd0, 32'h1, 3'b000);
      wait_seen(8);
      chk("lenerr_last_kept", 64'(cap.iaddr), 64'h9);
      chk("lenerr_count", 64'(got_err), 64'd3);

      // Pass-through formats and an over-long context packet
      send_pkt(8'd2, {8'h3F, 8'hFF, 112'h0});
      send_pkt(8'd1, {8'hDF, 120'h0});
      send_pkt(8'd3, {8'hE2, 8'hFF, 8'hFF, 104'h0});
      wait_seen(11);
      chk("ctx_sf", 64'(cap.sf), 64'd2);
      chk("ctx_priv", 64'(cap.priv), 64'd1);

      // Consumer backpressure
      pkt_ready_i = 1'b0;
      addr_only(32'h1234_5678, 3'b010);
      begin
         int guard = 0;
         while (!pkt_valid_o && guard < 50) begin
            @(negedge clk);
            guard++;
         end
      end
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 64'(pkt_valid_o), 64'd1);
         chk("bp_byte_ready", 64'(byte_ready_o), 64'd0);
         chk("bp_iaddr", 64'(iaddr_o), 64'h12345678);
      end
      @(posedge clk);
      #1 pkt_ready_i = 1'b1;
      wait_seen(12);

      // Reset in the middle of a payload
      send_byte(8'd10, t);
      send_byte(8'h40, t);
      send_byte(8'h55, t);
      rst_ni = 1'b0;
      model_last = 32'h0;
      @(negedge clk);
      chk("midrst_valid", 64'(pkt_valid_o), 64'd0);
      chk("midrst_byte_ready", 64'(byte_ready_o), 64'd0);
      chk("midrst_iaddr", 64'(iaddr_o), 64'd0);
      chk("midrst_fmt", 64'(format_o), 64'd0);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      diff_delta(5'd2, 31'd3, 32'h20, 3'b000);
      wait_seen(13);
      chk("post_rst_iaddr", 64'(cap.iaddr), 64'h20);

      repeat (5) @(posedge clk);
      #1;
      chk("total_len_err", 64'(got_err), 64'(exp_err));
      chk("queue_drained", 64'(expq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

endmodule
